// File: rtl/nec_pkg.sv
// NEC IR link shared definitions: FSM state encoding and default frame timing.
// The timing defaults are common to the transmitter and to the ir_rx thresholds.
package nec_pkg;

  typedef logic [2:0] nec_state_t;

  localparam nec_state_t ST_IDLE       = 3'd0;
  localparam nec_state_t ST_LEAD_MARK  = 3'd1;
  localparam nec_state_t ST_LEAD_SPACE = 3'd2;
  localparam nec_state_t ST_BIT_MARK   = 3'd3;
  localparam nec_state_t ST_BIT_SPACE  = 3'd4;
  localparam nec_state_t ST_STOP_MARK  = 3'd5;
  localparam nec_state_t ST_GAP        = 3'd6;

  localparam int NEC_TICK_DIV      = 50;     // clk cycles per 1 us at 50 MHz
  localparam int NEC_CARR_HALF     = 658;    // ~38 kHz carrier half-period
  localparam int NEC_LEAD_MARK_US  = 9000;
  localparam int NEC_LEAD_SPACE_US = 4500;
  localparam int NEC_BIT_MARK_US   = 560;
  localparam int NEC_ZERO_SPACE_US = 560;
  localparam int NEC_ONE_SPACE_US  = 1690;
  localparam int NEC_GAP_US        = 40000;

  // Segment lengths are counted in 1 us ticks; 16 bits covers the 40 ms gap.
  localparam int NEC_DUR_W = 16;

  // Marks are the states in which the LED envelope is on.
  function automatic logic is_mark(input nec_state_t s);
    return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
  endfunction

endpackage

// File: rtl/nec_tick_gen.sv
// Timing-tick divider: a one-clk enable strobe every TICK_DIV clks while en=1.
// restart realigns the phase so the first tick lands TICK_DIV clks later.
module nec_tick_gen
  import nec_pkg::*;
#(
  parameter int TICK_DIV = NEC_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Down-counter, reloads on terminal count or on restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
    end
  end

  assign tick = en & (cnt == '0);

endmodule

// File: rtl/ir_tx.sv
// NEC-format IR transmitter: serialises a 32-bit code MSB first into a
// carrier-modulated frame (lead mark/space, 32 bits, stop mark, gap).
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | waiting for i_start, outputs low
// LEAD_MARK  | 9 ms lead burst, envelope on
// LEAD_SPACE | 4.5 ms lead space, envelope off
// BIT_MARK   | 560 us burst starting bit idx
// BIT_SPACE  | space whose length encodes sh[idx] (1690 / 560 us)
// STOP_MARK  | closing 560 us burst
// GAP        | trailing space before returning to IDLE
module ir_tx
  import nec_pkg::*;
#(
  parameter int TICK_DIV      = NEC_TICK_DIV,
  parameter int CARR_HALF     = NEC_CARR_HALF,
  parameter int LEAD_MARK_US  = NEC_LEAD_MARK_US,
  parameter int LEAD_SPACE_US = NEC_LEAD_SPACE_US,
  parameter int BIT_MARK_US   = NEC_BIT_MARK_US,
  parameter int ZERO_SPACE_US = NEC_ZERO_SPACE_US,
  parameter int ONE_SPACE_US  = NEC_ONE_SPACE_US,
  parameter int GAP_US        = NEC_GAP_US
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ir_env,
  output logic        o_ir_tx
);

  localparam int CW = (CARR_HALF > 1) ? $clog2(CARR_HALF) : 1;
  localparam logic [CW-1:0] CARR_RELOAD = CW'(CARR_HALF - 1);

  nec_state_t           state;
  nec_state_t           state_nxt;
  logic [31:0]          sh;
  logic [4:0]           idx;
  logic [NEC_DUR_W-1:0] dur;
  logic [NEC_DUR_W-1:0] dur_load;
  logic [CW-1:0]        carr_cnt;
  logic                 tick;
  logic                 accept;
  logic                 seg_end;
  logic                 busy_nxt;
  logic                 env_nxt;
  logic                 done_nxt;

  assign accept  = (state == ST_IDLE) & i_start;
  assign seg_end = tick & (dur == NEC_DUR_W'(1));

  nec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state != ST_IDLE),
    .restart (accept),
    .tick    (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: each segment ends on the tick that exhausts its duration.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (accept)  state_nxt = ST_LEAD_MARK;
      ST_LEAD_MARK:  if (seg_end) state_nxt = ST_LEAD_SPACE;
      ST_LEAD_SPACE: if (seg_end) state_nxt = ST_BIT_MARK;
      ST_BIT_MARK:   if (seg_end) state_nxt = ST_BIT_SPACE;
      ST_BIT_SPACE:  if (seg_end) state_nxt = (idx == 5'd0) ? ST_STOP_MARK : ST_BIT_MARK;
      ST_STOP_MARK:  if (seg_end) state_nxt = ST_GAP;
      ST_GAP:        if (seg_end) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    busy_nxt = (state_nxt != ST_IDLE);
    env_nxt  = is_mark(state_nxt);
    done_nxt = (state == ST_GAP) && (state_nxt == ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_ir_env <= 1'b0;
    end else begin
      o_busy   <= busy_nxt;
      o_done   <= done_nxt;
      o_ir_env <= env_nxt;
    end
  end

  // Duration to load for the segment being entered; the bit space length
  // follows the bit currently indexed.
  always_comb begin
    dur_load = '0;
    case (state_nxt)
      ST_LEAD_MARK:  dur_load = NEC_DUR_W'(LEAD_MARK_US);
      ST_LEAD_SPACE: dur_load = NEC_DUR_W'(LEAD_SPACE_US);
      ST_BIT_MARK:   dur_load = NEC_DUR_W'(BIT_MARK_US);
      ST_BIT_SPACE:  dur_load = sh[idx] ? NEC_DUR_W'(ONE_SPACE_US) : NEC_DUR_W'(ZERO_SPACE_US);
      ST_STOP_MARK:  dur_load = NEC_DUR_W'(BIT_MARK_US);
      ST_GAP:        dur_load = NEC_DUR_W'(GAP_US);
      default:       dur_load = '0;
    endcase
  end

  // Shift register, bit index and segment duration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      idx <= '0;
      dur <= '0;
    end else begin
      if (accept) begin
        sh <= i_data;
      end
      if (state_nxt != state) begin
        dur <= dur_load;
      end else if (tick) begin
        dur <= dur - NEC_DUR_W'(1);
      end
      if ((state == ST_LEAD_SPACE) && (state_nxt == ST_BIT_MARK)) begin
        idx <= 5'd31;
      end else if ((state == ST_BIT_SPACE) && (state_nxt == ST_BIT_MARK)) begin
        idx <= idx - 5'd1;
      end
    end
  end

  // Carrier: starts high at every mark entry, toggles every CARR_HALF clks,
  // held low outside marks so o_ir_tx can never be on with the envelope off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ir_tx  <= 1'b0;
      carr_cnt <= '0;
    end else if (env_nxt && !o_ir_env) begin
      o_ir_tx  <= 1'b1;
      carr_cnt <= CARR_RELOAD;
    end else if (env_nxt) begin
      if (carr_cnt == '0) begin
        o_ir_tx  <= ~o_ir_tx;
        carr_cnt <= CARR_RELOAD;
      end else begin
        carr_cnt <= carr_cnt - CW'(1);
      end
    end else begin
      o_ir_tx  <= 1'b0;
      carr_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ir_tx.sv
// Bench for ir_tx with scaled-down timing so whole frames simulate quickly.
module tb_ir_tx;

  localparam int TD = 2;   // clks per tick
  localparam int CH = 3;   // carrier half-period, clks
  localparam int LM = 18;
  localparam int LS = 9;
  localparam int BM = 2;
  localparam int ZS = 2;
  localparam int OS = 5;
  localparam int GP = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_data = '0;
  logic        o_busy, o_done, o_ir_env, o_ir_tx;

  int n_vec = 0;
  int n_err = 0;

  ir_tx #(
    .TICK_DIV(TD), .CARR_HALF(CH), .LEAD_MARK_US(LM), .LEAD_SPACE_US(LS),
    .BIT_MARK_US(BM), .ZERO_SPACE_US(ZS), .ONE_SPACE_US(OS), .GAP_US(GP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_data(i_data),
    .o_busy(o_busy), .o_done(o_done), .o_ir_env(o_ir_env), .o_ir_tx(o_ir_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          exp_len;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame length from the closed-form rule, independent of the segment list.
  function automatic int frame_len(input logic [31:0] d);
    int n1;
    n1 = $countones(d);
    return TD * (LM + LS + 32 * BM + n1 * OS + (32 - n1) * ZS + BM + GP);
  endfunction

  // Sends one frame and checks it cycle by cycle against a segment list.
  // pre: i_start was already raised by the previous frame's chain request.
  // poke_at: cycle at which a conflicting i_start is pulsed (-1 = none).
  // chain: raise i_start with nd in the cycle o_done is seen.
  task automatic send_frame(input logic [31:0] d, input bit pre, input int poke_at,
                            input bit chain, input logic [31:0] nd, output int done_at);
    int lens[$];
    bit lvls[$];
    int runs[$];
    int L, seg, off, run_len;
    int bad_env, bad_tx, bad_busy;
    bit run_lvl, exp_env, exp_tx;
    logic [31:0] dec;

    lens.push_back(TD * LM); lvls.push_back(1'b1);
    lens.push_back(TD * LS); lvls.push_back(1'b0);
    for (int b = 31; b >= 0; b--) begin
      lens.push_back(TD * BM); lvls.push_back(1'b1);
      lens.push_back(TD * (d[b] ? OS : ZS)); lvls.push_back(1'b0);
    end
    lens.push_back(TD * BM); lvls.push_back(1'b1);
    lens.push_back(TD * GP); lvls.push_back(1'b0);
    L = 0;
    foreach (lens[i]) L += lens[i];

    if (!pre) begin
      i_data  = d;
      i_start = 1'b1;
    end
    @(negedge clk);
    i_start = 1'b0;
    i_data  = $urandom;

    seg = 0; off = 0; done_at = -1; run_len = 0; run_lvl = 1'b1;
    bad_env = -1; bad_tx = -1; bad_busy = -1;
    for (int t = 0; t < L; t++) begin
      exp_env = lvls[seg];
      exp_tx  = exp_env && (((off / CH) % 2) == 0);
      if (o_ir_env !== exp_env && bad_env < 0) bad_env = t;
      if (o_ir_tx  !== exp_tx  && bad_tx  < 0) bad_tx  = t;
      if (o_busy   !== 1'b1    && bad_busy < 0) bad_busy = t;
      if (o_done   !== 1'b0    && done_at < 0) done_at = t;
      if (o_ir_env === run_lvl) run_len++;
      else begin
        runs.push_back(run_len);
        run_lvl = o_ir_env;
        run_len = 1;
      end
      if (t == poke_at) begin
        i_start = 1'b1;
        i_data  = ~d;
      end else if (t == poke_at + 1) begin
        i_start = 1'b0;
      end
      off++;
      if (off == lens[seg]) begin
        seg++;
        off = 0;
      end
      @(negedge clk);
    end
    runs.push_back(run_len);
    if (o_done === 1'b1 && done_at < 0) done_at = L;

    check("env_trace_first_bad_cycle", bad_env, -1);
    check("tx_trace_first_bad_cycle", bad_tx, -1);
    check("busy_trace_first_bad_cycle", bad_busy, -1);
    check("accept_to_done_clks", done_at, frame_len(d));
    check("busy_at_done", o_busy, 0);
    check("env_at_done", o_ir_env, 0);
    check("tx_at_done", o_ir_tx, 0);
    check("envelope_run_count", runs.size(), 68);
    if (runs.size() == 68) begin
      for (int i = 0; i < 32; i++) dec[31 - i] = (runs[3 + 2 * i] > (TD * (ZS + OS)) / 2);
      check("loopback_decoded_data", dec, d);
    end
    if (chain) begin
      i_data  = nd;
      i_start = 1'b1;
    end else begin
      @(negedge clk);
      check("done_single_pulse", o_done, 0);
      check("idle_after_frame", o_busy, 0);
    end
  endtask

  vec_t tbl[4];

  initial begin
    int dat;
    logic [31:0] d;
    int off, dones;

    tbl[0] = '{32'h0000_0000, 334};
    tbl[1] = '{32'hFFFF_FFFF, 526};
    tbl[2] = '{32'h00FF_A25D, 430};
    tbl[3] = '{32'h8000_0001, 346};

    repeat (3) @(negedge clk);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_env", o_ir_env, 0);
    check("reset_tx", o_ir_tx, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy_no_start", o_busy, 0);

    for (int i = 0; i < 4; i++) begin
      send_frame(tbl[i].data, 1'b0, -1, 1'b0, 32'h0, dat);
      check("table_frame_len", dat, tbl[i].exp_len);
    end

    // i_start with different data mid-frame must be ignored.
    send_frame(32'h1357_9BDF, 1'b0, 100, 1'b0, 32'h0, dat);

    // Back-to-back: request in the o_done cycle starts the next frame.
    send_frame(32'hCAFE_F00D, 1'b0, -1, 1'b1, 32'h0F0F_1234, dat);
    send_frame(32'h0F0F_1234, 1'b1, -1, 1'b0, 32'h0, dat);

    for (int i = 0; i < 4; i++) begin
      send_frame($urandom, 1'b0, -1, 1'b0, 32'h0, dat);
    end

    // Async reset during the space of bit 12 aborts with no o_done.
    d = 32'h5A5A_1234;
    off = TD * (LM + LS);
    for (int b = 31; b > 12; b--) off += TD * (BM + (d[b] ? OS : ZS));
    off += TD * BM;
    i_data  = d;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (off + 1) @(negedge clk);
    check("pre_reset_busy", o_busy, 1);
    check("pre_reset_env_in_space", o_ir_env, 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_busy", o_busy, 0);
    check("async_reset_env", o_ir_env, 0);
    check("async_reset_tx", o_ir_tx, 0);
    check("async_reset_done", o_done, 0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_busy !== 1'b0) dones++;
    end
    check("reset_hold_quiet", dones, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(32'hA5C3_0F96, 1'b0, -1, 1'b0, 32'h0, dat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
